// File: rtl/tap_ir_dr_core.sv
// IR and DR stage behind a JTAG TAP controller: 4-bit IR, BYPASS, IDCODE and
// USER data registers, driven by the controller's 4-bit state code.
module tap_ir_dr_core #(
  parameter int unsigned        IR_W       = 4,
  parameter logic [IR_W-1:0]    IR_CAPTURE = IR_W'(4'b0101),
  parameter logic [31:0]        IDCODE_VAL = 32'h0A5C_0001,
  parameter int unsigned        USER_W     = 8,
  parameter logic [IR_W-1:0]    OP_IDCODE  = IR_W'(4'b0001),
  parameter logic [IR_W-1:0]    OP_USER    = IR_W'(4'b0010),
  parameter logic [IR_W-1:0]    OP_BYPASS  = IR_W'(4'b1111)
) (
  input  logic              GCLK_Pad,
  input  logic              TRST_Pad,
  input  logic [3:0]        state_obs,
  input  logic              TDI_Pad,
  output logic              TDO_Pad,
  output logic              tdo_en,
  output logic [IR_W-1:0]   ir_q,
  output logic [USER_W-1:0] user_q,
  output logic              user_upd
);

  localparam logic [3:0] S_TLR   = 4'hF;
  localparam logic [3:0] S_CAPDR = 4'h6;
  localparam logic [3:0] S_SHDR  = 4'h2;
  localparam logic [3:0] S_UPDDR = 4'h5;
  localparam logic [3:0] S_CAPIR = 4'hE;
  localparam logic [3:0] S_SHIR  = 4'hA;
  localparam logic [3:0] S_UPDIR = 4'hD;

  logic [IR_W-1:0]   r_ir_q;
  logic [IR_W-1:0]   r_ir_sh;
  logic              r_bypass;
  logic [31:0]       r_id_sh;
  logic [USER_W-1:0] r_usr_sh;
  logic [USER_W-1:0] r_user_q;
  logic              r_user_upd;
  logic              w_sel_id;
  logic              w_sel_usr;
  logic              w_sel_byp;
  logic              w_tdo;
  logic              w_shift;

  // OP_BYPASS and every undefined opcode fall through to the bypass register.
  assign w_sel_id  = (r_ir_q == OP_IDCODE);
  assign w_sel_usr = (r_ir_q == OP_USER);
  assign w_sel_byp = !w_sel_id && !w_sel_usr;

  // Instruction register: capture/shift stage plus the updated instruction.
  always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
    if (!TRST_Pad) begin
      r_ir_q  <= OP_IDCODE;
      r_ir_sh <= '0;
    end else begin
      case (state_obs)
        S_TLR:   r_ir_q  <= OP_IDCODE;
        S_CAPIR: r_ir_sh <= IR_CAPTURE;
        S_SHIR:  r_ir_sh <= {TDI_Pad, r_ir_sh[IR_W-1:1]};
        S_UPDIR: r_ir_q  <= r_ir_sh;
        default: ;
      endcase
    end
  end

  // Data registers: only the register selected by the current IR acts.
  always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
    if (!TRST_Pad) begin
      r_bypass   <= 1'b0;
      r_id_sh    <= '0;
      r_usr_sh   <= '0;
      r_user_q   <= '0;
      r_user_upd <= 1'b0;
    end else begin
      r_user_upd <= 1'b0;
      case (state_obs)
        S_CAPDR: begin
          if (w_sel_byp) r_bypass <= 1'b0;
          if (w_sel_id)  r_id_sh  <= IDCODE_VAL;
          if (w_sel_usr) r_usr_sh <= r_user_q;
        end
        S_SHDR: begin
          if (w_sel_byp) r_bypass <= TDI_Pad;
          if (w_sel_id)  r_id_sh  <= {TDI_Pad, r_id_sh[31:1]};
          if (w_sel_usr) r_usr_sh <= {TDI_Pad, r_usr_sh[USER_W-1:1]};
        end
        S_UPDDR: begin
          if (w_sel_usr) begin
            r_user_q   <= r_usr_sh;
            r_user_upd <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Serial output mux; forced low while reset is held.
  always_comb begin
    w_tdo   = 1'b0;
    w_shift = 1'b0;
    case (state_obs)
      S_SHIR: begin
        w_tdo   = r_ir_sh[0];
        w_shift = 1'b1;
      end
      S_SHDR: begin
        w_shift = 1'b1;
        if (w_sel_id)       w_tdo = r_id_sh[0];
        else if (w_sel_usr) w_tdo = r_usr_sh[0];
        else                w_tdo = r_bypass;
      end
      default: ;
    endcase
  end

  assign TDO_Pad  = w_tdo & TRST_Pad;
  assign tdo_en   = w_shift & TRST_Pad;
  assign ir_q     = r_ir_q;
  assign user_q   = r_user_q;
  assign user_upd = r_user_upd;

endmodule

// File: doc/tap_ir_dr_core.md
Name: tap_ir_dr_core

Overview:
- Instruction-register and data-register stage directly downstream of the TAP controller.
- Consumes the controller's 4-bit state code (state_obs3..0) plus TDI.
- Implements a 4-bit IR, a 1-bit BYPASS DR, a 32-bit IDCODE DR and an 8-bit USER DR with parallel output.
- Drives TDO.
- All logic is clocked on the same GCLK_Pad as the TAP controller.

Parameters:
- IR_W, 4: instruction register width.
- IR_CAPTURE, 4'b0101: value loaded into the IR shift stage in Capture-IR. The two LSBs must be 01.
- IDCODE_VAL, 32'h0A5C_0001: device ID. LSB must be 1.
- USER_W, 8: USER data register width.
- OP_IDCODE, 4'b0001: IDCODE opcode.
- OP_USER, 4'b0010: USER opcode.
- OP_BYPASS, 4'b1111: BYPASS opcode. Every undefined opcode also decodes as BYPASS.

Ports:
- GCLK_Pad, in, 1: clock, rising-edge active.
- TRST_Pad, in, 1: reset, asynchronous, active-low.
- state_obs, in, 4: TAP state code, valid for the whole cycle before each rising edge.
- TDI_Pad, in, 1: serial test data in.
- TDO_Pad, out, 1: serial test data out.
- tdo_en, out, 1: high while in Shift-IR or Shift-DR.
- ir_q, out, IR_W: current (updated) instruction.
- user_q, out, USER_W: parallel USER register.
- user_upd, out, 1: one-cycle pulse when user_q is updated.

Behaviour:
- State encoding (fixed, IEEE 1149.1 Annex encoding):
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
- Reset (TRST_Pad=0, asynchronous):
  - ir_q=OP_IDCODE; IR shift stage=0; bypass=0; ID shift=0; USER shift=0.
  - user_q=0, user_upd=0, TDO_Pad=0, tdo_en=0.
  - Reset asserted mid-shift aborts the shift; no update occurs.
- TLR at a rising edge: ir_q <= OP_IDCODE (synchronous). user_q is untouched.
- IR path, evaluated at each rising edge:
  - CapIR: ir_sh <= IR_CAPTURE.
  - ShIR: ir_sh <= {TDI_Pad, ir_sh[IR_W-1:1]}, LSB first.
  - UpdIR: ir_q <= ir_sh.
  - Any other state: hold.
- DR selection: decoded from ir_q (IDCODE, USER, else BYPASS). Selection is stable through the whole DR scan.
- DR path, only the selected register acts:
  - CapDR: bypass <= 0; id_sh <= IDCODE_VAL; usr_sh <= user_q.
  - ShDR: right-shift with TDI_Pad entering the MSB. Bypass is a single flop loaded from TDI_Pad.
  - UpdDR with USER selected: user_q <= usr_sh and user_upd=1 for exactly that one cycle. Otherwise user_upd=0.
  - IDCODE and BYPASS have no update effect.
- TDO_Pad (combinational from registers and state_obs):
  - In ShIR: ir_sh[0].
  - In ShDR: LSB of the selected DR.
  - Otherwise: 0.
  - tdo_en = (state_obs==ShIR) || (state_obs==ShDR).
- Latency:
  - BYPASS: 1 cycle TDI→TDO.
  - IR shift: the bit presented on TDI reaches TDO IR_W shifts later.
  - A new IR value becomes effective the cycle after the UpdIR edge.
- Pause and Exit states hold all shift contents, so a shift can resume after Ex2→Sh.
- An unknown or illegal state code behaves as "hold": no register changes and TDO=0.

Test Plan:
1. Reset, then read IDCODE:
   - Stimulus: TRST_Pad low then high; sequence RTI, SelDR, CapDR, ShDR×32, Ex1DR, UpdDR; TDI=0.
   - Required: ir_q=0001; TDO serially emits 32'h0A5C_0001 LSB first (first bit 1).
2. IR capture and load BYPASS:
   - Stimulus: CapIR, ShIR×4 with TDI bits 1,1,1,1, UpdIR.
   - Required: TDO emits 1,0,1,0 (capture 0101); ir_q=1111 after UpdIR.
3. BYPASS data path:
   - Stimulus: with ir_q=1111, CapDR then ShDR×5 with TDI=1,0,1,1,0.
   - Required: TDO=0,1,0,1,1 (one-cycle delay, leading 0 from capture).
4. USER write and readback:
   - Stimulus: load IR=0010; scan 8'hA5 LSB first; UpdDR.
   - Required: user_q=8'hA5 with user_upd high for exactly 1 cycle.
   - Stimulus: second scan with TDI=0.
   - Required: TDO=1,0,1,0,0,1,0,1.
5. Undefined opcode:
   - Stimulus: load IR=0110, then DR scan.
   - Required: 1-bit bypass behaviour; user_q unchanged.
6. Reset and Pause cases:
   - Stimulus: TRST_Pad pulsed low during ShDR of a USER scan.
   - Required: all registers return to reset values immediately; user_q=0, ir_q=0001.
   - Stimulus: ShDR×3, PauDR×4, Ex2DR, ShDR×5.
   - Required: contents resume correctly.
